ws2812_tx: RTL

- Output end of the ambient-light pipeline: consumes the per-block averaged colour stream (24-bit GRB word, `dataready` strobe, block index) produced by the HDMI block-averaging front end.
- Stores one colour per LED in an internal buffer.
- On request, serialises the whole buffer onto a single WS2812-style LED data line (NRZ pulse-width code), followed by a latch/reset low period.
- Runs entirely in the `cal_clk` domain.

---
 rtl/ws2812_tx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ws2812_tx.sv
// ws2812_tx: buffers one GRB word per LED and serialises the buffer onto a
// WS2812-style NRZ data line, followed by a low latch period.
// Ports: cal_clk/rst (sync, active-high); GRBin/dataready/block_idx write
// port; frame_go refresh request; led_dout serial line; busy frame in
// progress; done one-cycle pulse at end of latch.
// Optional: define WS2812_BRIGHT_EN to add the 8-bit bright input, which
// scales each channel by (bright+1)/256.
module ws2812_tx #(
  parameter int LED_NUM      = 96,
  parameter int ADDR_W       = 7,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int TBIT         = 62,
  parameter int RESET_CYCLES = 15000
) (
  input  logic        cal_clk,
  input  logic        rst,
  input  logic [23:0] GRBin,
  input  logic        dataready,
  input  logic [9:0]  block_idx,
  input  logic        frame_go,
`ifdef WS2812_BRIGHT_EN
  input  logic [7:0]  bright,
`endif
  output logic        led_dout,
  output logic        busy,
  output logic        done
);

  localparam int CMAX =
    (RESET_CYCLES > TBIT) ? RESET_CYCLES : TBIT;
  localparam int CW = $clog2(CMAX);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BIT,
    LATCH
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [23:0]       sr_q, sr_d;
  logic              pend_q, pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [23:0]       mem_q [LED_NUM];
  logic [23:0]       rdata_q;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       word_in;
  logic              last_led;

  assign last_led = (idx_q == ADDR_W'(LED_NUM - 1));

  // Buffer: nonblocking read and write on the same edge give
  // read-before-write ordering when addresses collide.
  always_ff @(posedge cal_clk) begin
    if (dataready && (block_idx < 10'(LED_NUM)))
      mem_q[block_idx[ADDR_W-1:0]] <= GRBin;
    if (rd_en)
      rdata_q <= mem_q[rd_addr];
  end

`ifdef WS2812_BRIGHT_EN
  logic [7:0] bright_q;
  logic [7:0] bsel;

  function automatic logic [7:0] scl(
    input logic [7:0] c,
    input logic [7:0] b
  );
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return 8'(p >> 8);
  endfunction

  // The first word is loaded in LOAD itself, before bright_q settles.
  assign bsel = (state_q == LOAD) ? bright : bright_q;

  assign word_in = {
    scl(rdata_q[23:16], bsel),
    scl(rdata_q[15:8],  bsel),
    scl(rdata_q[7:0],   bsel)
  };

  always_ff @(posedge cal_clk) begin
    if (rst)
      bright_q <= '0;
    else if (state_q == LOAD)
      bright_q <= bright;
  end
`else
  assign word_in = rdata_q;
`endif

  always_ff @(posedge cal_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      idx_q    <= '0;
      sr_q     <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      idx_q    <= idx_d;
      sr_q     <= sr_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    idx_d    = idx_q;
    sr_d     = sr_q;
    pend_d   = pend_q | (frame_go & busy_q);
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    unique case (state_q)
      IDLE: begin
        if (frame_go || pend_q) begin
          state_d = LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
          pend_d  = 1'b0;
          rd_en   = 1'b1;
        end
      end
      LOAD: begin
        sr_d     = word_in;
        bitcnt_d = '0;
        cnt_d    = '0;
        state_d  = BIT;
      end
      BIT: begin
        // Prefetch the next word at the start of bit 23.
        if (bitcnt_q == 5'd23 && cnt_q == '0 && !last_led) begin
          rd_en   = 1'b1;
          rd_addr = idx_q + ADDR_W'(1);
        end
        if (cnt_q == CW'(TBIT - 1)) begin
          cnt_d = '0;
          if (bitcnt_q == 5'd23) begin
            if (last_led) begin
              state_d = LATCH;
            end else begin
              sr_d     = word_in;
              idx_d    = idx_q + ADDR_W'(1);
              bitcnt_d = '0;
            end
          end else begin
            sr_d     = {sr_q[22:0], 1'b0};
            bitcnt_d = bitcnt_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LATCH: begin
        if (cnt_q == CW'(RESET_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = pend_d;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign led_dout = (state_q == BIT) &&
    (cnt_q < (sr_q[23] ? CW'(T1H) : CW'(T0H)));
  assign busy = busy_q;
  assign done = done_q;

endmodule
